// File: rtl/bus_ram_pkg.sv
// Shared definitions for the bus-side RAM target.
// Contents: default address/data widths and the handshake FSM state encoding.
package bus_ram_pkg;

  localparam int unsigned BUS_RAM_AW = 8;
  localparam int unsigned BUS_RAM_DW = 8;

  localparam int unsigned ST_W = 3;

  // Handshake FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RD_WAIT  = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_HOLD  = 3'd2;
  localparam logic [ST_W-1:0] ST_WR_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_ERR_HOLD = 3'd4;

endpackage

// File: rtl/bus_ram_mem.sv
// Single-port synchronous RAM, write-first, registered read address,
// no reset on the array so it maps onto an inferred block RAM.
// Ports:
//   clk      clock
//   en       access enable (registers the address, qualifies the write)
//   we       write enable
//   addr     word address (always < DEPTH)
//   wdata    write data
//   rdata_c  read data for the registered address
module bus_ram_mem #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned MAW   = 8
) (
  input  logic           clk,
  input  logic           en,
  input  logic           we,
  input  logic [MAW-1:0] addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata_c
);

  logic [DW-1:0]  mem [DEPTH];
  logic [MAW-1:0] addr_q;

  // Write and address capture share the edge, so a read of the same word
  // after a write sees the new data (write-first behaviour).
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      addr_q <= addr;
    end
  end

  assign rdata_c = mem[addr_q];

endmodule

// File: rtl/bus_ram_ctrl.sv
// Bus-side RAM target for the active-low strobe bus (bnRD/bnWR).
// Detects strobe falling edges, runs a read/write handshake FSM with ready and
// conflict flags, and drives read data through an explicit output enable so the
// top level builds the tristate DBus pad.
// Optional feature: define BUS_RAM_AUTOINC_EN for auto-incrementing burst
// addressing through an internal pointer (selected by bAutoInc).
// Ports:
//   bclk      bus clock
//   brst      asynchronous active-high reset
//   ABus      bus address
//   DBusIn    write data from the pad
//   DBusOut   read data to the pad
//   DBusOe    pad output enable
//   bnRD      read strobe, active-low
//   bnWR      write strobe, active-low
//   bAutoInc  use the internal pointer instead of ABus (feature builds only)
//   bRdy      access complete / data valid
//   bErr      strobe conflict
module bus_ram_ctrl
  import bus_ram_pkg::*;
#(
  parameter int unsigned AW    = BUS_RAM_AW,
  parameter int unsigned DW    = BUS_RAM_DW,
  parameter int unsigned DEPTH = 2**AW
) (
  input  logic          bclk,
  input  logic          brst,
  input  logic [AW-1:0] ABus,
  input  logic [DW-1:0] DBusIn,
  output logic [DW-1:0] DBusOut,
  output logic          DBusOe,
  input  logic          bnRD,
  input  logic          bnWR,
  input  logic          bAutoInc,
  output logic          bRdy,
  output logic          bErr
);

  localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic            rd_q;
  logic            wr_q;
  logic            smp_vld;
  logic            rd_start_c;
  logic            wr_start_c;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [DW-1:0]   dout_nxt;
  logic            oe_nxt;
  logic            rdy_nxt;
  logic            err_nxt;

  logic            mem_en_c;
  logic            mem_we_c;
  logic [DW-1:0]   mem_rdata_c;
  logic [AW-1:0]   sel_addr_c;
  logic [AW-1:0]   addr_wrap_c;

  // Strobe sample registers; smp_vld marks that rd_q/wr_q hold a real sample,
  // so a strobe already low when reset releases never looks like a fresh edge.
  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      smp_vld <= 1'b0;
    end else begin
      rd_q    <= bnRD;
      wr_q    <= bnWR;
      smp_vld <= 1'b1;
    end
  end

  assign rd_start_c = smp_vld & rd_q & ~bnRD;
  assign wr_start_c = smp_vld & wr_q & ~bnWR;

  // Address selection and wrap into the implemented depth
`ifdef BUS_RAM_AUTOINC_EN
  logic [AW-1:0] ptr;
  logic [AW-1:0] addr_inc_c;

  assign sel_addr_c = bAutoInc ? ptr : ABus;
  assign addr_inc_c = (addr_wrap_c == AW'(DEPTH - 1)) ? '0 : addr_wrap_c + AW'(1);

  // Pointer follows every memory access, including reads that later abort
  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      ptr <= '0;
    end else if (mem_en_c) begin
      ptr <= addr_inc_c;
    end
  end
`else
  logic unused_autoinc;

  assign sel_addr_c     = ABus;
  assign unused_autoinc = bAutoInc;
`endif

  assign addr_wrap_c = AW'(64'(sel_addr_c) % 64'(DEPTH));

  // State and registered outputs
  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      state   <= ST_IDLE;
      DBusOut <= '0;
      DBusOe  <= 1'b0;
      bRdy    <= 1'b0;
      bErr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      DBusOut <= dout_nxt;
      DBusOe  <= oe_nxt;
      bRdy    <= rdy_nxt;
      bErr    <= err_nxt;
    end
  end

  // Next state, next outputs and memory controls
  always_comb begin
    state_nxt = state;
    dout_nxt  = DBusOut;
    oe_nxt    = DBusOe;
    rdy_nxt   = bRdy;
    err_nxt   = bErr;
    mem_en_c  = 1'b0;
    mem_we_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        if ((rd_start_c || wr_start_c) && !bnRD && !bnWR) begin
          state_nxt = ST_ERR_HOLD;
          err_nxt   = 1'b1;
        end else if (rd_start_c) begin
          mem_en_c  = 1'b1;
          state_nxt = ST_RD_WAIT;
        end else if (wr_start_c) begin
          mem_en_c  = 1'b1;
          mem_we_c  = 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = ST_WR_HOLD;
        end
      end

      ST_RD_WAIT: begin
        if (bnRD) begin
          state_nxt = ST_IDLE;
        end else begin
          dout_nxt  = mem_rdata_c;
          oe_nxt    = 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = ST_RD_HOLD;
        end
      end

      ST_RD_HOLD: begin
        if (bnRD) begin
          oe_nxt    = 1'b0;
          rdy_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      ST_WR_HOLD: begin
        if (bnWR) begin
          rdy_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      ST_ERR_HOLD: begin
        if (bnRD && bnWR) begin
          err_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        oe_nxt    = 1'b0;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
      end
    endcase
  end

  bus_ram_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .MAW   (MAW)
  ) u_mem (
    .clk     (bclk),
    .en      (mem_en_c),
    .we      (mem_we_c),
    .addr    (MAW'(addr_wrap_c)),
    .wdata   (DBusIn),
    .rdata_c (mem_rdata_c)
  );

endmodule

// File: doc/bus_ram_ctrl.md
# bus_ram_ctrl

Parametrised synchronous RAM target for the active-low strobe bus (`bnRD`/`bnWR`, `ABus`, `DBus`). It is the bus-side memory used by the test benches and board top levels. It detects strobe edges and runs a read/write handshake state machine with a ready flag and a conflict flag. It drives read data through an explicit output-enable, so the top level builds the tristate `DBus` pad, and it optionally supports auto-incrementing burst addressing.

## Interface
Parameters:
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `DEPTH`, default 2**AW: number of words. Must be ≤ 2**AW. Addresses ≥ DEPTH wrap modulo DEPTH.

Ports:
- `bclk`  in  1  bus clock; single clock domain.
- `brst`  in  1  reset, asynchronous, active-high.
- `ABus`  in  AW  bus address.
- `DBusIn`  in  DW  write data from the pad.
- `DBusOut`  out  DW  read data to the pad.
- `DBusOe`  out  1  pad output enable; the top level drives `DBus` = `DBusOut` when this is 1, else Z.
- `bnRD`  in  1  read strobe, active-low, synchronous to `bclk`.
- `bnWR`  in  1  write strobe, active-low, synchronous to `bclk`.
- `bAutoInc`  in  1  use the internal pointer instead of `ABus`. Ignored without `BUS_RAM_AUTOINC_EN`.
- `bRdy`  out  1  access complete / data valid.
- `bErr`  out  1  strobe conflict (both strobes asserted).

## Operation
- Strobe sample registers `rd_q`/`wr_q` reset to 1 (deasserted). A start is a sampled high→low transition. A strobe held low through reset release does not start an access.
- FSM states (encoding in package): `IDLE`, `RD_WAIT`, `RD_HOLD`, `WR_HOLD`, `ERR_HOLD`.
- From `IDLE`:
  - Read start with `bnWR`=1: assert mem read with the selected address, go to `RD_WAIT`.
  - Write start with `bnRD`=1: write `DBusIn` to the selected address in the same cycle, go to `WR_HOLD`.
  - Both strobes low, on a start edge of either: go to `ERR_HOLD`, no memory access.
- `RD_WAIT`:
  - `bnRD`=1 (abort): go to `IDLE`, no output enable.
  - Otherwise: capture mem q into `DBusOut`, go to `RD_HOLD`.
- `RD_HOLD`: `DBusOe`=1 and `bRdy`=1 while `bnRD`=0. On `bnRD`=1, go to `IDLE`.
- `WR_HOLD`: `bRdy`=1 until `bnWR`=1, then go to `IDLE`. No second write while the strobe is held.
- `ERR_HOLD`: `bErr`=1 until both strobes are high, then go to `IDLE`.
- The opposite strobe asserting during `RD_HOLD` or `WR_HOLD` is ignored; it is not treated as a start.
- Read-after-write to the same address returns the new data.
- Reset values:
  - `DBusOut`=0, `DBusOe`=0, `bRdy`=0, `bErr`=0.
  - State = `IDLE`; pointer = 0.
  - Memory array is not cleared.
- Reset mid-access: immediate return to `IDLE` and outputs to reset values. An in-flight write whose edge has already occurred is kept.

## Timing
- Edge k = first `bclk` edge that samples the strobe low after a high sample.
- Write: memory updated at edge k. `bRdy`=1 from edge k until the edge after `bnWR` is sampled high.
- Read:
  - Mem address registered at edge k.
  - `DBusOut`, `DBusOe` and `bRdy` valid from edge k+1.
  - Read latency is 2 sampled cycles from the strobe falling.
- `DBusOe` falls at the first edge that samples `bnRD`=1.
- Minimum strobe-high gap between accesses: 1 cycle.

## Configuration
- `BUS_RAM_AUTOINC_EN` defined:
  - Access with `bAutoInc`=0 uses `ABus` and loads pointer = `ABus`+1.
  - Access with `bAutoInc`=1 uses the pointer, then increments it.
  - The pointer increments at the access edge (edge k), modulo DEPTH; DEPTH-1 wraps to 0.
  - Aborted reads still increment.
- `BUS_RAM_AUTOINC_EN` undefined: no pointer register; `ABus` always addresses; `bAutoInc` unused.

## Structure
- `bus_ram_pkg`: FSM state enum and default `AW`/`DW` constants.
- Sub-module `bus_ram_mem`:
  - Single-port synchronous RAM (`DW`×`DEPTH`).
  - Write-first.
  - Registered read address.
  - No reset on the array.
  - Maps to inferred block RAM.

## Test plan
- Write 8'hA5 to 8'h10, then read 8'h10 → `DBusOe` and `bRdy` high at edge k+1 with `DBusOut`=8'hA5. `DBusOe` falls one edge after `bnRD` rises.
- Hold `bnWR` low for 5 cycles while `DBusIn` changes 8'h11→8'h22 → memory holds 8'h11 (single write); `bRdy` high for 5 cycles.
- Drop both strobes in the same cycle → `bErr`=1, no write, `bRdy`=0. `bErr` clears one edge after both strobes rise.
- Release `bnRD` at edge k+1 (abort in `RD_WAIT`) → `DBusOe` never asserts, FSM returns to `IDLE`.
- With `BUS_RAM_AUTOINC_EN`: write at `ABus`=8'hFE, then two burst writes → addresses 8'hFF and 8'h00 written (wrap). Reading them back matches.
- Assert `brst` during `RD_HOLD` while `bnRD` is held low → outputs reset at once. No new read starts until `bnRD` rises and falls again.
